dice_roller: RTL and testbench

Parametrised multi-die electronic dice for the exercise designs. It rolls N_DICE dice of FACES faces while `button` is held. Release is debounced; the block then freezes the dice, registers their sum and holds the result behind a valid/ack handshake. Two roll modes are supported: deterministic odometer, and LFSR-gated pseudo-random.

---
 rtl/dice_pkg.sv | 20 ++
 rtl/dice_lfsr.sv | 22 ++
 rtl/dice_roller.sv | 141 ++++++++++++++
 tb/tb_dice_roller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the electronic dice: controller states, LFSR constants
// and roll-mode encodings.
package dice_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROLL,
    SETTLE,
    SUM,
    HOLD
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic MODE_ODOMETER = 1'b0;
  localparam logic MODE_LFSR     = 1'b1;

endpackage

// File: rtl/dice_lfsr.sv
// 16-bit free-running Fibonacci LFSR used to gate die advances in random mode.
module dice_lfsr
  import dice_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/dice_roller.sv
// Multi-die electronic dice: rolls while the button is held, debounces the
// release, then freezes the dice and presents their sum behind valid/ack.
module dice_roller
  import dice_pkg::*;
#(
  parameter int  N_DICE   = 2,
  parameter int  FACES    = 6,
  parameter int  DEBOUNCE = 4,
  localparam int FW       = $clog2(FACES + 1),
  localparam int SW       = $clog2(N_DICE * FACES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 button,
  input  logic                 mode,
  input  logic                 ack,
  output logic [N_DICE*FW-1:0] throw,
  output logic [SW-1:0]        sum,
  output logic                 valid,
  output logic                 rolling
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [FW-1:0] FACE_MAX = FW'(FACES);
  localparam logic [FW-1:0] DIE_ONE  = FW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE - 1);

  state_t          state_reg, state_next;
  logic            mode_reg, mode_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            load_sum;
  logic            advance;
  logic [15:0]     lfsr;
  logic [N_DICE-1:0] step;
  logic [FW-1:0]   die_reg [N_DICE];
  logic [SW-1:0]   sum_reg, sum_all;

  dice_lfsr u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .lfsr (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_ODOMETER;
      cnt_reg   <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      cnt_reg   <= cnt_next;
      if (load_sum) begin
        sum_reg <= sum_all;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;
    load_sum   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (button) begin
          state_next = ROLL;
          mode_next  = mode;
        end
      end
      ROLL: begin
        if (!button) begin
          state_next = SETTLE;
          cnt_next   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (button) begin
          state_next = ROLL;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          state_next = SUM;
        end
      end
      SUM: begin
        load_sum   = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        // a new press abandons the held result even if ack arrives with it
        if (button) begin
          state_next = ROLL;
        end else if (ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign advance = (state_reg == ROLL) || (state_reg == SETTLE);

  // odometer: each die steps when its lower neighbour wraps FACES -> 1
  always_comb begin
    logic carry;
    carry = 1'b1;
    step  = '0;
    for (int k = 0; k < N_DICE; k++) begin
      step[k] = (mode_reg == MODE_LFSR) ? lfsr[4'(k % 16)] : carry;
      carry   = step[k] && (die_reg[k] == FACE_MAX);
    end
  end

  for (genvar gi = 0; gi < N_DICE; gi++) begin : g_die
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        die_reg[gi] <= DIE_ONE;
      end else if (die_reg[gi] == '0 || die_reg[gi] > FACE_MAX) begin
        die_reg[gi] <= DIE_ONE;
      end else if (advance && step[gi]) begin
        die_reg[gi] <= (die_reg[gi] == FACE_MAX) ? DIE_ONE : die_reg[gi] + DIE_ONE;
      end
    end

    assign throw[gi*FW +: FW] = die_reg[gi];
  end

  always_comb begin
    sum_all = '0;
    for (int k = 0; k < N_DICE; k++) begin
      sum_all = sum_all + SW'(die_reg[k]);
    end
  end

  assign sum     = sum_reg;
  assign valid   = (state_reg == HOLD);
  assign rolling = advance;

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: a 2x6 instance with a cycle model for the
// random mode, and a 3x8 instance exercising full-scale sums and carry wrap.
module tb_dice_roller;

  localparam int FW_A = 3;
  localparam int SW_A = 4;
  localparam int FW_B = 4;
  localparam int SW_B = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic button, mode, ack;
  logic button_b, ack_b;
  logic [2*FW_A-1:0] throw_a;
  logic [SW_A-1:0]   sum_a;
  logic              valid_a, rolling_a;
  logic [3*FW_B-1:0] throw_b;
  logic [SW_B-1:0]   sum_b;
  logic              valid_b, rolling_b;

  int total = 0;
  int bad   = 0;
  logic track = 1'b0;

  typedef enum {M_IDLE, M_ROLL, M_SETTLE, M_SUM, M_HOLD} m_state_t;
  typedef struct {
    logic [15:0] lfsr;
    m_state_t    st;
    logic        md;
    int          cnt;
    int          d0;
    int          d1;
  } mdl_t;
  typedef struct {
    int d0;
    int d1;
    int d2;
    int sum;
    bit use_mdl;
  } exp_t;

  mdl_t mdl;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic va_prev = 1'b0;
  logic vb_prev = 1'b0;

  always #5 clk = ~clk;

  dice_roller #(.N_DICE(2), .FACES(6), .DEBOUNCE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .button(button), .mode(mode), .ack(ack),
    .throw(throw_a), .sum(sum_a), .valid(valid_a), .rolling(rolling_a)
  );

  dice_roller #(.N_DICE(3), .FACES(8), .DEBOUNCE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .button(button_b), .mode(1'b0), .ack(ack_b),
    .throw(throw_b), .sum(sum_b), .valid(valid_b), .rolling(rolling_b)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int inc6(input int v);
    return (v == 6) ? 1 : v + 1;
  endfunction

  // Behavioural reference for the 2x6 instance
  function automatic mdl_t mstep(input mdl_t m, input logic b, input logic md, input logic a);
    mdl_t n = m;
    if (m.st == M_ROLL || m.st == M_SETTLE) begin
      if (m.md) begin
        if (m.lfsr[0]) n.d0 = inc6(m.d0);
        if (m.lfsr[1]) n.d1 = inc6(m.d1);
      end else begin
        n.d0 = inc6(m.d0);
        if (m.d0 == 6) n.d1 = inc6(m.d1);
      end
    end
    case (m.st)
      M_IDLE:   if (b) begin n.st = M_ROLL; n.md = md; end
      M_ROLL:   if (!b) begin n.st = M_SETTLE; n.cnt = 3; end
      M_SETTLE: if (b) n.st = M_ROLL;
                else if (m.cnt != 0) n.cnt = m.cnt - 1;
                else n.st = M_SUM;
      M_SUM:    n.st = M_HOLD;
      M_HOLD:   if (b) n.st = M_ROLL; else if (a) n.st = M_IDLE;
      default:  n.st = M_IDLE;
    endcase
    n.lfsr = {m.lfsr[14:0], m.lfsr[15] ^ m.lfsr[13] ^ m.lfsr[12] ^ m.lfsr[10]};
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl <= '{lfsr: 16'hACE1, st: M_IDLE, md: 1'b0, cnt: 0, d0: 1, d1: 1};
    end else begin
      mdl <= mstep(mdl, button, mode, ack);
    end
  end

  // per-cycle throw tracking against the reference
  always @(negedge clk) begin
    if (rst_n && track) begin
      check("trk_d0", int'(throw_a[FW_A-1:0]), mdl.d0);
      check("trk_d1", int'(throw_a[2*FW_A-1:FW_A]), mdl.d1);
    end
  end

  always @(negedge clk) begin
    va_prev <= valid_a;
    if (rst_n && valid_a && !va_prev) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_a_unexpected: valid rose with no expected result, sum=%0d", sum_a);
      end else begin
        ea = qa.pop_front();
        if (ea.use_mdl) begin
          ea.d0  = mdl.d0;
          ea.d1  = mdl.d1;
          ea.sum = mdl.d0 + mdl.d1;
        end
        check("sb_a_d0", int'(throw_a[FW_A-1:0]), ea.d0);
        check("sb_a_d1", int'(throw_a[2*FW_A-1:FW_A]), ea.d1);
        check("sb_a_sum", int'(sum_a), ea.sum);
        $display("result A: throw={%0d,%0d} sum=%0d", throw_a[2*FW_A-1:FW_A], throw_a[FW_A-1:0], sum_a);
      end
    end
  end

  always @(negedge clk) begin
    vb_prev <= valid_b;
    if (rst_n && valid_b && !vb_prev) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_b_unexpected: valid rose with no expected result, sum=%0d", sum_b);
      end else begin
        eb = qb.pop_front();
        check("sb_b_d0", int'(throw_b[3:0]), eb.d0);
        check("sb_b_d1", int'(throw_b[7:4]), eb.d1);
        check("sb_b_d2", int'(throw_b[11:8]), eb.d2);
        check("sb_b_sum", int'(sum_b), eb.sum);
        $display("result B: throw={%0d,%0d,%0d} sum=%0d", throw_b[11:8], throw_b[7:4], throw_b[3:0], sum_b);
      end
    end
  end

  task automatic wait_valid_a(input int lim);
    int n = 0;
    while (!valid_a && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid_a", int'(valid_a), 1);
  endtask

  task automatic wait_valid_b(input int lim);
    int n = 0;
    while (!valid_b && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid_b", int'(valid_b), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; button = 1'b0; mode = 1'b0; ack = 1'b0;
    button_b = 1'b0; ack_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_d0", int'(throw_a[FW_A-1:0]), 1);
    check("rst_a_d1", int'(throw_a[2*FW_A-1:FW_A]), 1);
    check("rst_a_sum", int'(sum_a), 0);
    check("rst_a_valid", int'(valid_a), 0);
    check("rst_a_rolling", int'(rolling_a), 0);
    check("rst_b_throw", int'(throw_b), 12'h111);
    rst_n = 1'b1;
    track = 1'b1;

    // 12 advancing edges in odometer mode; a mid-roll mode flip must be ignored
    button = 1'b1;
    @(negedge clk);
    check("start_rolling", int'(rolling_a), 1);
    check("start_no_adv", int'(throw_a[FW_A-1:0]), 1);
    repeat (2) @(negedge clk);
    mode = 1'b1;
    repeat (5) @(negedge clk);
    button = 1'b0;
    mode = 1'b0;
    qa.push_back('{d0: 1, d1: 3, d2: 0, sum: 4, use_mdl: 1'b0});
    repeat (5) @(negedge clk);
    check("settle_valid_low", int'(valid_a), 0);
    check("sum_state_not_rolling", int'(rolling_a), 0);
    @(negedge clk);
    check("valid_timing", int'(valid_a), 1);
    $display("txn odometer12: valid=%0d sum=%0d", valid_a, sum_a);

    // ack returns to IDLE holding the result
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid", int'(valid_a), 0);
    check("ack_rolling", int'(rolling_a), 0);
    check("ack_keep_d1", int'(throw_a[2*FW_A-1:FW_A]), 3);
    check("ack_keep_sum", int'(sum_a), 4);
    $display("txn ack: valid=%0d sum=%0d", valid_a, sum_a);

    // four-cycle release glitch must not end the roll
    button = 1'b1;
    repeat (5) @(negedge clk);
    button = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("glitch_rolling", int'(rolling_a), 1);
      check("glitch_valid", int'(valid_a), 0);
    end
    button = 1'b1;
    repeat (3) @(negedge clk);
    button = 1'b0;
    qa.push_back('{d0: 5, d1: 5, d2: 0, sum: 10, use_mdl: 1'b0});
    wait_valid_a(20);
    $display("txn glitch: sum=%0d", sum_a);

    // button and ack together in HOLD: the new roll wins
    button = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("btn_ack_valid", int'(valid_a), 0);
    check("btn_ack_rolling", int'(rolling_a), 1);
    @(negedge clk);
    button = 1'b0;
    qa.push_back('{d0: 5, d1: 6, d2: 0, sum: 11, use_mdl: 1'b0});
    wait_valid_a(20);
    $display("txn btn_over_ack: sum=%0d", sum_a);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // LFSR-gated roll with a mid-roll mode flip
    mode = 1'b1;
    button = 1'b1;
    repeat (10) @(negedge clk);
    mode = 1'b0;
    repeat (10) @(negedge clk);
    button = 1'b0;
    qa.push_back('{d0: 0, d1: 0, d2: 0, sum: 0, use_mdl: 1'b1});
    wait_valid_a(20);
    $display("txn lfsr_roll: sum=%0d", sum_a);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // asynchronous reset while settling
    button = 1'b1;
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_rolling", int'(rolling_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_d0", int'(throw_a[FW_A-1:0]), 1);
    check("arst_d1", int'(throw_a[2*FW_A-1:FW_A]), 1);
    check("arst_sum", int'(sum_a), 0);
    check("arst_valid", int'(valid_a), 0);
    check("arst_rolling", int'(rolling_a), 0);
    $display("txn async_reset: rolling=%0d sum=%0d", rolling_a, sum_a);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3x8: 511 advances reach {8,8,8}, then one more wraps every die
    button_b = 1'b1;
    repeat (507) @(negedge clk);
    button_b = 1'b0;
    qb.push_back('{d0: 8, d1: 8, d2: 8, sum: 24, use_mdl: 1'b0});
    wait_valid_b(20);
    button_b = 1'b1;
    @(negedge clk);
    button_b = 1'b0;
    @(negedge clk);
    check("carry_d0", int'(throw_b[3:0]), 1);
    check("carry_d1", int'(throw_b[7:4]), 1);
    check("carry_d2", int'(throw_b[11:8]), 1);
    $display("txn carry: throw=%03h", throw_b);
    qb.push_back('{d0: 5, d1: 1, d2: 1, sum: 7, use_mdl: 1'b0});
    wait_valid_b(20);

    repeat (3) @(negedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
